// File: rtl/sdrc_arb_pkg.sv
// Shared definitions for the sdrc application-port arbiter.
// State encodings, requester limits and the FSM state type.
package sdrc_arb_pkg;

    localparam int NREQ_MAX = 4;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_REQ   = 2'd1;
    localparam logic [1:0] ARB_WDATA = 2'd2;
    localparam logic [1:0] ARB_RDATA = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ARB_IDLE,
        ST_REQ   = ARB_REQ,
        ST_WDATA = ARB_WDATA,
        ST_RDATA = ARB_RDATA
    } arb_state_e;

endpackage

// File: rtl/sdrc_app_arb_if.sv
// sdrc_core application request port as seen by the arbiter.
// master: arbiter side (drives request/write data); slave: core side.
interface sdrc_app_arb_if #(
    parameter int APP_AW = 26,
    parameter int APP_DW = 32,
    parameter int APP_BW = 4,
    parameter int bl     = 9
);
    logic              app_req;
    logic [APP_AW-1:0] app_req_addr;
    logic [bl-1:0]     app_req_len;
    logic              app_req_wr_n;
    logic              app_req_ack;
    logic [APP_DW-1:0] app_wr_data;
    logic [APP_BW-1:0] app_wr_en_n;
    logic              app_wr_next_req;
    logic              app_rd_valid;
    logic              app_last_rd;
    logic [APP_DW-1:0] app_rd_data;

    modport master (
        output app_req, app_req_addr, app_req_len, app_req_wr_n,
        output app_wr_data, app_wr_en_n,
        input  app_req_ack, app_wr_next_req,
        input  app_rd_valid, app_last_rd, app_rd_data
    );

    modport slave (
        input  app_req, app_req_addr, app_req_len, app_req_wr_n,
        input  app_wr_data, app_wr_en_n,
        output app_req_ack, app_wr_next_req,
        output app_rd_valid, app_last_rd, app_rd_data
    );
endinterface

// File: rtl/sdrc_rr_pick.sv
// Combinational round-robin picker: first set req bit after 'last'.
// Ports: req (request vector), last (previous winner) -> grant, valid.
module sdrc_rr_pick
    import sdrc_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic [1:0]      grant,
    output logic            valid
);

    // Padded so a 2-bit index is always in range for any NREQ.
    logic [NREQ_MAX-1:0] req_pad;
    logic [1:0]          idx;

    assign req_pad = NREQ_MAX'(req);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        // Scan last+1 .. last+NREQ; the last slot is 'last' itself.
        for (int i = 1; i <= NREQ; i++) begin
            idx = 2'((int'(last) + i) % NREQ);
            if (!valid && req_pad[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/sdrc_app_arb.sv
// Round-robin arbiter/sequencer sharing the sdrc_core app port.
// Ports: sdram_clk/sdram_resetn, sdr_init_done, packed rq_* requesters, app (core), arb_owner/arb_busy.
module sdrc_app_arb
    import sdrc_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int APP_AW = 26,
    parameter int APP_DW = 32,
    parameter int APP_BW = 4,
    parameter int bl     = 9
) (
    input  logic                 sdram_clk,
    input  logic                 sdram_resetn,
    input  logic                 sdr_init_done,

    input  logic [NREQ-1:0]        rq_req,
    input  logic [NREQ*APP_AW-1:0] rq_addr,
    input  logic [NREQ*bl-1:0]     rq_len,
    input  logic [NREQ-1:0]        rq_wr_n,
    input  logic [NREQ*APP_DW-1:0] rq_wr_data,
    input  logic [NREQ*APP_BW-1:0] rq_wr_en_n,
    output logic [NREQ-1:0]        rq_ack,
    output logic [NREQ-1:0]        rq_wr_next,
    output logic [NREQ-1:0]        rq_rd_valid,
    output logic [NREQ-1:0]        rq_last_rd,
    output logic [APP_DW-1:0]      rq_rd_data,

    sdrc_app_arb_if.master       app,

    output logic [1:0]           arb_owner,
    output logic                 arb_busy
);

    arb_state_e        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [1:0]        last_q, last_d;
    logic [APP_AW-1:0] addr_q, addr_d;
    logic [bl-1:0]     len_q, len_d;
    logic [bl-1:0]     cnt_q, cnt_d;
    logic              wr_n_q, wr_n_d;
    logic [NREQ-1:0]   ack_q, ack_d;

    logic [NREQ-1:0]     pick_req;
    logic [1:0]          pick_idx;
    logic                pick_vld;
    logic [APP_AW-1:0]   pick_addr;
    logic [bl-1:0]       pick_len;
    logic [NREQ_MAX-1:0] wr_n_pad;
    logic                pick_wr_n;

    // A zero-length requester is still holding rq_req during its ack
    // cycle; mask it so it is not granted a second time.
    assign pick_req = rq_req & ~ack_q;

    sdrc_rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (pick_req),
        .last  (last_q),
        .grant (pick_idx),
        .valid (pick_vld)
    );

    assign wr_n_pad  = NREQ_MAX'(rq_wr_n);
    assign pick_wr_n = wr_n_pad[pick_idx];
    assign pick_addr = rq_addr[int'(pick_idx)*APP_AW +: APP_AW];
    assign pick_len  = rq_len[int'(pick_idx)*bl +: bl];

    always_ff @(posedge sdram_clk) begin
        if (!sdram_resetn) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= 2'(NREQ - 1);
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            wr_n_q  <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wr_n_q  <= wr_n_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        wr_n_d  = wr_n_q;
        ack_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (sdr_init_done && pick_vld) begin
                    owner_d = pick_idx;
                    addr_d  = pick_addr;
                    len_d   = pick_len;
                    wr_n_d  = pick_wr_n;
                    cnt_d   = pick_len;
                    if (pick_len == '0) begin
                        ack_d  = NREQ'(1) << pick_idx;
                        last_d = pick_idx;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (app.app_req_ack) begin
                    ack_d   = NREQ'(1) << owner_q;
                    last_d  = owner_q;
                    state_d = wr_n_q ? ST_RDATA : ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (app.app_wr_next_req) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == bl'(1)) state_d = ST_IDLE;
                end
            end
            ST_RDATA: begin
                if (app.app_rd_valid && app.app_last_rd) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign app.app_req      = (state_q == ST_REQ);
    assign app.app_req_addr = addr_q;
    assign app.app_req_len  = len_q;
    assign app.app_req_wr_n = wr_n_q;

    assign app.app_wr_data = (state_q == ST_WDATA)
        ? rq_wr_data[int'(owner_q)*APP_DW +: APP_DW] : '0;
    assign app.app_wr_en_n = (state_q == ST_WDATA)
        ? rq_wr_en_n[int'(owner_q)*APP_BW +: APP_BW] : '1;

    // Beat strobes go to the owner only, and only in the matching phase.
    always_comb begin
        rq_wr_next  = '0;
        rq_rd_valid = '0;
        rq_last_rd  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == 2'(i)) begin
                rq_wr_next[i]  = (state_q == ST_WDATA) & app.app_wr_next_req;
                rq_rd_valid[i] = (state_q == ST_RDATA) & app.app_rd_valid;
                rq_last_rd[i]  = (state_q == ST_RDATA) & app.app_last_rd;
            end
        end
    end

    assign rq_ack     = ack_q;
    assign rq_rd_data = app.app_rd_data;
    assign arb_owner  = owner_q;
    assign arb_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdrc_app_arb.sv
// Directed testbench for sdrc_app_arb (NREQ=2).
// Drives requesters and a scripted core, checks against hand-computed values.
module tb_sdrc_app_arb;

    logic        clk;
    logic        sdram_resetn;
    logic        sdr_init_done;
    logic [1:0]  rq_req;
    logic [51:0] rq_addr;
    logic [17:0] rq_len;
    logic [1:0]  rq_wr_n;
    logic [63:0] rq_wr_data;
    logic [7:0]  rq_wr_en_n;
    logic [1:0]  rq_ack;
    logic [1:0]  rq_wr_next;
    logic [1:0]  rq_rd_valid;
    logic [1:0]  rq_last_rd;
    logic [31:0] rq_rd_data;
    logic [1:0]  arb_owner;
    logic        arb_busy;

    int vectors = 0;
    int miscompares = 0;

    sdrc_app_arb_if #(.APP_AW(26), .APP_DW(32), .APP_BW(4), .bl(9)) app ();

    sdrc_app_arb #(
        .NREQ(2), .APP_AW(26), .APP_DW(32), .APP_BW(4), .bl(9)
    ) dut (
        .sdram_clk     (clk),
        .sdram_resetn  (sdram_resetn),
        .sdr_init_done (sdr_init_done),
        .rq_req        (rq_req),
        .rq_addr       (rq_addr),
        .rq_len        (rq_len),
        .rq_wr_n       (rq_wr_n),
        .rq_wr_data    (rq_wr_data),
        .rq_wr_en_n    (rq_wr_en_n),
        .rq_ack        (rq_ack),
        .rq_wr_next    (rq_wr_next),
        .rq_rd_valid   (rq_rd_valid),
        .rq_last_rd    (rq_last_rd),
        .rq_rd_data    (rq_rd_data),
        .app           (app),
        .arb_owner     (arb_owner),
        .arb_busy      (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_ack;
        app.app_req_ack = 1'b1;
        tick();
        app.app_req_ack = 1'b0;
    endtask

    task automatic set_rq(input int i, input logic [25:0] a, input logic [8:0] l,
                          input logic w, input logic [31:0] d, input logic [3:0] be);
        rq_addr[i*26 +: 26]   = a;
        rq_len[i*9 +: 9]      = l;
        rq_wr_n[i]            = w;
        rq_wr_data[i*32 +: 32] = d;
        rq_wr_en_n[i*4 +: 4]  = be;
    endtask

    task automatic test_reset;
        sdram_resetn = 1'b0;
        sdr_init_done = 1'b1;
        rq_req = 2'b00;
        rq_addr = '0; rq_len = '0; rq_wr_n = '0;
        rq_wr_data = 64'h1111_2222_3333_4444;
        rq_wr_en_n = 8'h00;
        app.app_req_ack = 1'b0; app.app_wr_next_req = 1'b0;
        app.app_rd_valid = 1'b0; app.app_last_rd = 1'b0;
        app.app_rd_data = '0;
        tick(); tick();
        vectors++;
        if (app.app_req !== 1'b0) begin miscompares++;
            $display("FAIL reset_app_req got=%b exp=0", app.app_req); end
        vectors++;
        if ({arb_busy, arb_owner} !== 3'b000) begin miscompares++;
            $display("FAIL reset_busy_owner got=%b exp=000", {arb_busy, arb_owner}); end
        vectors++;
        if (app.app_wr_en_n !== 4'hF) begin miscompares++;
            $display("FAIL reset_wr_en_n got=%h exp=f", app.app_wr_en_n); end
        vectors++;
        if (app.app_wr_data !== 32'h0) begin miscompares++;
            $display("FAIL reset_wr_data got=%h exp=0", app.app_wr_data); end
        vectors++;
        if ({rq_ack, rq_wr_next, rq_rd_valid, rq_last_rd} !== 8'h00) begin miscompares++;
            $display("FAIL reset_rq_flags got=%h exp=00",
                     {rq_ack, rq_wr_next, rq_rd_valid, rq_last_rd}); end
        vectors++;
        if ({app.app_req_addr, app.app_req_len, app.app_req_wr_n} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_req_fields got=%h exp=0",
                     {app.app_req_addr, app.app_req_len, app.app_req_wr_n}); end
    endtask

    task automatic test_rr_order;
        set_rq(0, 26'h0000100, 9'd1, 1'b1, 32'h0, 4'hF);
        set_rq(1, 26'h0000200, 9'd1, 1'b1, 32'h0, 4'hF);
        rq_req = 2'b11;
        sdram_resetn = 1'b1;
        tick();
        vectors++;
        if ({app.app_req, arb_owner, app.app_req_addr} !== {1'b1, 2'd0, 26'h100}) begin
            miscompares++;
            $display("FAIL rr_first_grant got=%b/%0d/%h exp=1/0/100",
                     app.app_req, arb_owner, app.app_req_addr); end
        do_ack();
        vectors++;
        if (rq_ack !== 2'b01) begin miscompares++;
            $display("FAIL rr_ack0 got=%b exp=01", rq_ack); end
        app.app_rd_valid = 1'b1; app.app_last_rd = 1'b1;
        app.app_rd_data = 32'hA5A5_0001;
        #1;
        vectors++;
        if ({rq_rd_valid, rq_last_rd, rq_rd_data} !== {2'b01, 2'b01, 32'hA5A5_0001}) begin
            miscompares++;
            $display("FAIL rr_read0 got=%b/%b/%h exp=01/01/a5a50001",
                     rq_rd_valid, rq_last_rd, rq_rd_data); end
        tick();
        app.app_rd_valid = 1'b0; app.app_last_rd = 1'b0;
        vectors++;
        if ({arb_busy, rq_ack} !== 3'b000) begin miscompares++;
            $display("FAIL rr_dead_cycle got=%b exp=000", {arb_busy, rq_ack}); end
        tick();
        vectors++;
        if ({app.app_req, arb_owner, app.app_req_addr} !== {1'b1, 2'd1, 26'h200}) begin
            miscompares++;
            $display("FAIL rr_second_grant got=%b/%0d/%h exp=1/1/200",
                     app.app_req, arb_owner, app.app_req_addr); end
        do_ack();
        vectors++;
        if (rq_ack !== 2'b10) begin miscompares++;
            $display("FAIL rr_ack1 got=%b exp=10", rq_ack); end
        app.app_rd_valid = 1'b1; app.app_last_rd = 1'b1;
        tick();
        app.app_rd_valid = 1'b0; app.app_last_rd = 1'b0;
        tick();
        vectors++;
        if ({app.app_req, arb_owner} !== {1'b1, 2'd0}) begin miscompares++;
            $display("FAIL rr_third_grant got=%b/%0d exp=1/0", app.app_req, arb_owner); end
        do_ack();
        rq_req = 2'b00;
        app.app_rd_valid = 1'b1; app.app_last_rd = 1'b1;
        tick();
        app.app_rd_valid = 1'b0; app.app_last_rd = 1'b0;
    endtask

    task automatic test_write_len4;
        set_rq(0, 26'h0000001, 9'd4, 1'b0, 32'hD000_0000, 4'h0);
        set_rq(1, 26'h00ABCDE, 9'd4, 1'b0, 32'hD100_0000, 4'h3);
        rq_req = 2'b10;
        tick();
        vectors++;
        if ({arb_owner, app.app_req, app.app_req_len, app.app_req_wr_n}
            !== {2'd1, 1'b1, 9'd4, 1'b0}) begin miscompares++;
            $display("FAIL wr_grant got=%0d/%b/%0d/%b exp=1/1/4/0", arb_owner,
                     app.app_req, app.app_req_len, app.app_req_wr_n); end
        do_ack();
        rq_req = 2'b00;
        vectors++;
        if (rq_ack !== 2'b10) begin miscompares++;
            $display("FAIL wr_ack got=%b exp=10", rq_ack); end
        for (int k = 0; k < 4; k++) begin
            rq_wr_data[32 +: 32] = 32'hD100_0000 + 32'(k);
            app.app_wr_next_req = 1'b1;
            #1;
            vectors++;
            if (rq_wr_next !== 2'b10) begin miscompares++;
                $display("FAIL wr_next_%0d got=%b exp=10", k, rq_wr_next); end
            vectors++;
            if ({app.app_wr_data, app.app_wr_en_n} !== {32'hD100_0000 + 32'(k), 4'h3}) begin
                miscompares++;
                $display("FAIL wr_data_%0d got=%h/%h exp=%h/3", k, app.app_wr_data,
                         app.app_wr_en_n, 32'hD100_0000 + 32'(k)); end
            tick();
            app.app_wr_next_req = 1'b0;
            #1;
            vectors++;
            if ({arb_busy, rq_wr_next} !== {(k < 3), 2'b00}) begin miscompares++;
                $display("FAIL wr_after_%0d got=%b exp=%b", k, {arb_busy, rq_wr_next},
                         {(k < 3), 2'b00}); end
            if (k < 3) tick();
        end
        vectors++;
        if ({app.app_wr_data, app.app_wr_en_n} !== {32'h0, 4'hF}) begin miscompares++;
            $display("FAIL wr_idle_bus got=%h/%h exp=0/f", app.app_wr_data, app.app_wr_en_n); end
    endtask

    task automatic test_read_len8;
        set_rq(0, 26'h0002000, 9'd8, 1'b1, 32'h0, 4'hF);
        rq_req = 2'b01;
        tick();
        vectors++;
        if ({arb_owner, app.app_req, app.app_req_len, app.app_req_wr_n}
            !== {2'd0, 1'b1, 9'd8, 1'b1}) begin miscompares++;
            $display("FAIL rd_grant got=%0d/%b/%0d/%b exp=0/1/8/1", arb_owner,
                     app.app_req, app.app_req_len, app.app_req_wr_n); end
        do_ack();
        rq_req = 2'b00;
        vectors++;
        if (rq_ack !== 2'b01) begin miscompares++;
            $display("FAIL rd_ack got=%b exp=01", rq_ack); end
        for (int k = 0; k < 8; k++) begin
            app.app_rd_valid = 1'b1;
            app.app_last_rd = (k == 7);
            app.app_rd_data = 32'hBEEF_0000 + 32'(k);
            #1;
            vectors++;
            if ({rq_rd_valid, rq_last_rd, rq_rd_data}
                !== {2'b01, (k == 7) ? 2'b01 : 2'b00, 32'hBEEF_0000 + 32'(k)}) begin
                miscompares++;
                $display("FAIL rd_beat_%0d got=%b/%b/%h", k, rq_rd_valid, rq_last_rd,
                         rq_rd_data); end
            tick();
            app.app_rd_valid = 1'b0;
            app.app_last_rd = 1'b0;
            #1;
            vectors++;
            if ({arb_busy, rq_rd_valid} !== {(k < 7), 2'b00}) begin miscompares++;
                $display("FAIL rd_after_%0d got=%b exp=%b", k, {arb_busy, rq_rd_valid},
                         {(k < 7), 2'b00}); end
        end
    endtask

    task automatic test_zero_len;
        set_rq(1, 26'h0000003, 9'd0, 1'b1, 32'h0, 4'hF);
        rq_req = 2'b10;
        tick();
        vectors++;
        if ({rq_ack, app.app_req, arb_busy} !== {2'b10, 1'b0, 1'b0}) begin miscompares++;
            $display("FAIL zlen_ack got=%b/%b/%b exp=10/0/0", rq_ack, app.app_req, arb_busy); end
        tick();
        vectors++;
        if ({rq_ack, app.app_req, arb_busy} !== 4'b0000) begin miscompares++;
            $display("FAIL zlen_no_regrant got=%b/%b/%b exp=00/0/0", rq_ack, app.app_req,
                     arb_busy); end
        rq_req = 2'b00;
    endtask

    task automatic test_ack_delay;
        set_rq(0, 26'h155AAAA, 9'd1, 1'b0, 32'hCAFE_F00D, 4'h0);
        set_rq(1, 26'h0000004, 9'd2, 1'b0, 32'h0, 4'h0);
        rq_req = 2'b11;
        tick();
        rq_req = 2'b01;
        vectors++;
        if (arb_owner !== 2'd0) begin miscompares++;
            $display("FAIL dly_owner got=%0d exp=0", arb_owner); end
        for (int c = 0; c < 11; c++) begin
            vectors++;
            if ({app.app_req, app.app_req_addr, app.app_req_len, app.app_req_wr_n, rq_ack}
                !== {1'b1, 26'h155AAAA, 9'd1, 1'b0, 2'b00}) begin miscompares++;
                $display("FAIL dly_hold_%0d got=%b/%h/%0d/%b/%b", c, app.app_req,
                         app.app_req_addr, app.app_req_len, app.app_req_wr_n, rq_ack); end
            if (c == 10) app.app_req_ack = 1'b1;
            tick();
        end
        app.app_req_ack = 1'b0;
        rq_req = 2'b00;
        vectors++;
        if ({rq_ack, app.app_req} !== 3'b010) begin miscompares++;
            $display("FAIL dly_ack got=%b/%b exp=01/0", rq_ack, app.app_req); end
        app.app_wr_next_req = 1'b1;
        #1;
        vectors++;
        if (app.app_wr_data !== 32'hCAFE_F00D) begin miscompares++;
            $display("FAIL dly_wdata got=%h exp=cafef00d", app.app_wr_data); end
        tick();
        app.app_wr_next_req = 1'b0;
        vectors++;
        if ({rq_ack, arb_busy} !== 3'b000) begin miscompares++;
            $display("FAIL dly_single_pulse got=%b/%b exp=00/0", rq_ack, arb_busy); end
    endtask

    task automatic test_reset_mid;
        set_rq(1, 26'h0000777, 9'd4, 1'b0, 32'h1234_5678, 4'h0);
        rq_req = 2'b10;
        tick();
        do_ack();
        rq_req = 2'b00;
        app.app_wr_next_req = 1'b1;
        tick();
        app.app_wr_next_req = 1'b0;
        vectors++;
        if ({arb_busy, app.app_wr_en_n} !== 5'b1_0000) begin miscompares++;
            $display("FAIL rstm_in_wdata got=%b/%h exp=1/0", arb_busy, app.app_wr_en_n); end
        sdram_resetn = 1'b0;
        tick();
        vectors++;
        if ({app.app_req, arb_busy, arb_owner, app.app_wr_en_n, app.app_wr_data}
            !== {1'b0, 1'b0, 2'd0, 4'hF, 32'h0}) begin miscompares++;
            $display("FAIL rstm_outputs got=%b/%b/%0d/%h/%h exp=0/0/0/f/0", app.app_req,
                     arb_busy, arb_owner, app.app_wr_en_n, app.app_wr_data); end
        vectors++;
        if ({app.app_req_addr, app.app_req_len, rq_ack, rq_wr_next} !== 39'h0) begin
            miscompares++;
            $display("FAIL rstm_fields got=%h/%0d/%b/%b exp=0/0/00/00", app.app_req_addr,
                     app.app_req_len, rq_ack, rq_wr_next); end
        sdram_resetn = 1'b1;
        set_rq(0, 26'h0000010, 9'd1, 1'b1, 32'h0, 4'hF);
        set_rq(1, 26'h0000020, 9'd1, 1'b1, 32'h0, 4'hF);
        rq_req = 2'b11;
        tick();
        vectors++;
        if ({app.app_req, arb_owner} !== {1'b1, 2'd0}) begin miscompares++;
            $display("FAIL rstm_regrant got=%b/%0d exp=1/0", app.app_req, arb_owner); end
        do_ack();
        rq_req = 2'b00;
        app.app_rd_valid = 1'b1; app.app_last_rd = 1'b1;
        tick();
        app.app_rd_valid = 1'b0; app.app_last_rd = 1'b0;
        vectors++;
        if (arb_busy !== 1'b0) begin miscompares++;
            $display("FAIL rstm_done got=%b exp=0", arb_busy); end
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_write_len4();
        test_read_len8();
        test_zero_len();
        test_ack_delay();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
